alu_rs_aged: RTL and testbench
==============================

# alu_rs_aged

Parametrised ALU reservation station for the Tomasulo back end. It sits between the Dispatcher and the CDB arbiter. It holds up to `RS_SIZE` integer/branch/jalr micro-ops, wakes them from CDB broadcasts, and issues the oldest ready entry to an embedded single-cycle ALU. The result goes to a registered valid/ready output so the arbiter can back-pressure it. Successor to the fixed 4-entry station: depth is parametrised, selection is age-ordered, dispatch-time CDB bypass is added, signed/unsigned compares are distinguished, and there is output handshaking.

## Interface
- `RS_WIDTH`, 3: log2 of entry count; `RS_SIZE = 1<<RS_WIDTH`.
- `ROB_WIDTH`, 3: ROB index width; tag value `1<<ROB_WIDTH` (`NON_DEP`) means the operand is valid.
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global enable; low freezes all state.
- `flush_in` in 1: synchronous mispredict flush.
- `disp_valid` in 1: dispatch request.
- `disp_ready` out 1: `rdy_in && !full`; combinational.
- `disp_op` in 7: opcode from the shared package.
- `disp_rob` in ROB_WIDTH: destination ROB index.
- `disp_vj`, `disp_vk`, `disp_imm`, `disp_pc` in 32 each: operand values, immediate, PC.
- `disp_qj`, `disp_qk` in ROB_WIDTH+1: operand tags.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_rob` in ROB_WIDTH: broadcast ROB index.
- `cdb_data` in 32: broadcast value.
- `out_valid` out 1: result valid.
- `out_ready` in 1: arbiter accepts the result.
- `out_rob` out ROB_WIDTH: result ROB index.
- `out_data` out 32: result value.
- `count` out RS_WIDTH+1: number of occupied entries.

## Operation
- Entry fields:
  - busy, op, vj, vk, qj, qk, imm, pc, rob.
  - Age matrix `older[i][j]`: entry i was allocated before entry j.
- Allocation (`disp_valid && disp_ready`):
  - Writes the lowest-index free entry.
  - Sets `older[k][new]=1` for every busy k, and clears `older[new][*]`.
- Dispatch bypass: if `cdb_valid` and `disp_qj == {1'b0,cdb_rob}`, the entry stores `qj=NON_DEP` and `vj=cdb_data`. Same rule for k.
- Wakeup: each busy entry whose qj/qk equals `{1'b0,cdb_rob}` while `cdb_valid` takes `cdb_data` and sets the tag to NON_DEP.
- Ready: busy and both tags NON_DEP. The selected entry is the ready entry with no older ready entry.
- Issue: occurs when a selected entry exists and the output slot is free (`!out_valid || out_ready`). On issue:
  - The ALU result is loaded into `out_*` and `out_valid` is set.
  - The entry is freed and its age column is cleared.
- Output hold: `out_valid && !out_ready` holds `out_*` and blocks issue.
- ALU, all 32-bit, result wraps modulo 2^32:
  - add/addi/sub: wrap modulo 2^32.
  - slt/slti/blt/bge: signed compares.
  - sltu/sltiu/bltu/bgeu: unsigned compares.
  - Shifts: use amount bits [4:0] only; sra/srai arithmetic.
  - Branches: produce 1 when taken, else 0.
  - jalr: `(vj+imm) & ~1`.
  - Undefined opcode: 0.
- Same-cycle events:
  - A CDB wakeup and an issue from a different entry both take effect.
  - The freed slot may be re-allocated the same cycle; the new entry is the youngest.
- Priority: `rst_in` > `flush_in` > `!rdy_in` (freeze) > normal.
- Flush: clears all busy bits, the age matrix and `out_valid`. Dispatch is ignored that cycle.

## Timing
- Reset values:
  - `out_valid=0`, `out_rob=0`, `out_data=0`, `count=0`, `disp_ready=0` while `rdy_in=0`.
  - All entries free and tags NON_DEP.
- With operands ready at dispatch, the edge that accepts dispatch is E; issue is at edge E+1 and `out_valid` is high after E+1. Minimum latency: 2 edges.
- A CDB broadcast at edge W makes the entry eligible for issue at edge W+1.
- `count` and `disp_ready` reflect the registered state. When full, `disp_ready` is 0 even if an issue frees a slot that cycle; there is no combinational full-bypass.
- Reset mid-operation: immediate asynchronous clear, including any held output.

## Structure
- Shared package `rv_pkg`: the 7-bit opcode localparams (jalr=4, beq..bgeu=5..10, addi..srai=19..27, add..and=28..37) and the `NON_DEP` helper.
- One sub-module: `rs_alu`, purely combinational (op, vj, vk, imm, pc → 32-bit result).
- Oldest-ready selection and free-slot priority encoders are generated loops, parametrised by `RS_SIZE`.

## Test plan
- Oldest-first: dispatch A(rob 5, qj=2) then B(rob 6, ready), then CDB rob 2. Required response:
  - B issues first.
  - Then A issues, with A's vj taken from the CDB value.
  - If A and B become ready together, A (older) issues first.
- Bypass: dispatch `add` with qj=3 in the same cycle as CDB rob 3 data 7, vk=5 → `out_data=12` after 2 edges.
- Back-pressure: hold `out_ready=0` with 3 ready entries → `out_*` stable, `count` stays 3; then release → 3 results in age order on consecutive cycles.
- Full: fill all 8 entries (RS_WIDTH=3) with unready ops → `disp_ready=0`, an extra dispatch is dropped, `count=8`.
- ALU corners, each with its expected result:
  - `slt` -1 vs 1 → 1.
  - `sltu` 0xFFFFFFFF vs 1 → 0.
  - `sra` 0x80000000 by 33 → 0xC0000000.
  - `jalr` vj=0x1001, imm=0 → 0x1000.
- Flush/reset: flush while output held and 4 entries busy → next cycle `out_valid=0`, `count=0`. Asserting `rst_in` mid-cycle clears outputs without waiting for a clock edge.

Source files
------------

// File: rtl/alu_rs_aged_pkg.sv
// Shared opcode encodings and tag helper for the integer back end.
package rv_pkg;

    localparam logic [6:0] OP_JALR  = 7'd4;

    localparam logic [6:0] OP_BEQ   = 7'd5;
    localparam logic [6:0] OP_BNE   = 7'd6;
    localparam logic [6:0] OP_BLT   = 7'd7;
    localparam logic [6:0] OP_BGE   = 7'd8;
    localparam logic [6:0] OP_BLTU  = 7'd9;
    localparam logic [6:0] OP_BGEU  = 7'd10;

    localparam logic [6:0] OP_ADDI  = 7'd19;
    localparam logic [6:0] OP_SLTI  = 7'd20;
    localparam logic [6:0] OP_SLTIU = 7'd21;
    localparam logic [6:0] OP_XORI  = 7'd22;
    localparam logic [6:0] OP_ORI   = 7'd23;
    localparam logic [6:0] OP_ANDI  = 7'd24;
    localparam logic [6:0] OP_SLLI  = 7'd25;
    localparam logic [6:0] OP_SRLI  = 7'd26;
    localparam logic [6:0] OP_SRAI  = 7'd27;

    localparam logic [6:0] OP_ADD   = 7'd28;
    localparam logic [6:0] OP_SUB   = 7'd29;
    localparam logic [6:0] OP_SLL   = 7'd30;
    localparam logic [6:0] OP_SLT   = 7'd31;
    localparam logic [6:0] OP_SLTU  = 7'd32;
    localparam logic [6:0] OP_XOR   = 7'd33;
    localparam logic [6:0] OP_SRL   = 7'd34;
    localparam logic [6:0] OP_SRA   = 7'd35;
    localparam logic [6:0] OP_OR    = 7'd36;
    localparam logic [6:0] OP_AND   = 7'd37;

    // Tag value meaning "operand already valid": one past the largest ROB index.
    function automatic int unsigned non_dep(input int unsigned rob_width);
        return 32'd1 << rob_width;
    endfunction

endpackage

// File: rtl/alu_rs_aged_alu.sv
// Single-cycle integer ALU used by the reservation station issue port.
module rs_alu
    import rv_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [31:0] vj,
    input  logic [31:0] vk,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    output logic [31:0] result
);

    // No current opcode consumes the PC; it stays on the port for future ops.
    logic unused_pc;
    assign unused_pc = ^pc;

    logic [31:0] jalr_sum;
    assign jalr_sum = vj + imm;

    // Opcode decode; branches yield 1 when taken, unknown opcodes yield 0.
    always_comb begin
        result = '0;
        case (op)
            OP_JALR:  result = jalr_sum & ~32'd1;
            OP_BEQ:   result = {31'd0, vj == vk};
            OP_BNE:   result = {31'd0, vj != vk};
            OP_BLT:   result = {31'd0, $signed(vj) <  $signed(vk)};
            OP_BGE:   result = {31'd0, $signed(vj) >= $signed(vk)};
            OP_BLTU:  result = {31'd0, vj <  vk};
            OP_BGEU:  result = {31'd0, vj >= vk};
            OP_ADDI:  result = vj + imm;
            OP_SLTI:  result = {31'd0, $signed(vj) < $signed(imm)};
            OP_SLTIU: result = {31'd0, vj < imm};
            OP_XORI:  result = vj ^ imm;
            OP_ORI:   result = vj | imm;
            OP_ANDI:  result = vj & imm;
            OP_SLLI:  result = vj << imm[4:0];
            OP_SRLI:  result = vj >> imm[4:0];
            OP_SRAI:  result = $unsigned($signed(vj) >>> imm[4:0]);
            OP_ADD:   result = vj + vk;
            OP_SUB:   result = vj - vk;
            OP_SLL:   result = vj << vk[4:0];
            OP_SLT:   result = {31'd0, $signed(vj) < $signed(vk)};
            OP_SLTU:  result = {31'd0, vj < vk};
            OP_XOR:   result = vj ^ vk;
            OP_SRL:   result = vj >> vk[4:0];
            OP_SRA:   result = $unsigned($signed(vj) >>> vk[4:0]);
            OP_OR:    result = vj | vk;
            OP_AND:   result = vj & vk;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rs_aged.sv
// Age-ordered ALU reservation station with CDB wakeup/bypass and a
// registered valid/ready result port.
module alu_rs_aged
    import rv_pkg::*;
#(
    parameter int unsigned RS_WIDTH  = 3,
    parameter int unsigned ROB_WIDTH = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [6:0]           disp_op,
    input  logic [ROB_WIDTH-1:0] disp_rob,
    input  logic [31:0]          disp_vj,
    input  logic [31:0]          disp_vk,
    input  logic [31:0]          disp_imm,
    input  logic [31:0]          disp_pc,
    input  logic [ROB_WIDTH:0]   disp_qj,
    input  logic [ROB_WIDTH:0]   disp_qk,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob,
    input  logic [31:0]          cdb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_WIDTH-1:0] out_rob,
    output logic [31:0]          out_data,
    output logic [RS_WIDTH:0]    count
);

    localparam int unsigned RS_SIZE = 1 << RS_WIDTH;
    localparam int unsigned TAG_W   = ROB_WIDTH + 1;
    localparam int unsigned CNT_W   = RS_WIDTH + 1;
    localparam logic [ROB_WIDTH:0] NON_DEP = TAG_W'(non_dep(ROB_WIDTH));

    logic [RS_SIZE-1:0]   busy;
    logic [6:0]           e_op  [RS_SIZE];
    logic [31:0]          e_vj  [RS_SIZE];
    logic [31:0]          e_vk  [RS_SIZE];
    logic [31:0]          e_imm [RS_SIZE];
    logic [31:0]          e_pc  [RS_SIZE];
    logic [ROB_WIDTH:0]   e_qj  [RS_SIZE];
    logic [ROB_WIDTH:0]   e_qk  [RS_SIZE];
    logic [ROB_WIDTH-1:0] e_rob [RS_SIZE];
    // older[i][j]: entry i was allocated before entry j
    logic [RS_SIZE-1:0]   older [RS_SIZE];

    logic [RS_SIZE-1:0]   ready;
    logic [RS_SIZE-1:0]   sel_vec;
    logic                 have_sel;
    logic [RS_WIDTH-1:0]  sel_idx;
    logic [RS_WIDTH-1:0]  free_idx;
    logic [ROB_WIDTH:0]   cdb_tag;
    logic                 do_issue;
    logic                 do_alloc;
    logic [31:0]          alu_res;

    assign cdb_tag    = {1'b0, cdb_rob};
    assign disp_ready = rdy_in && !(&busy);
    assign do_alloc   = disp_valid && disp_ready;
    assign do_issue   = have_sel && (!out_valid || out_ready);

    // An entry is selectable when ready and no older entry is also ready.
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_sel
        logic [RS_SIZE-1:0] col;
        for (genvar gj = 0; gj < RS_SIZE; gj++) begin : g_col
            assign col[gj] = older[gj][gi];
        end
        assign ready[gi]   = busy[gi] && (e_qj[gi] == NON_DEP) && (e_qk[gi] == NON_DEP);
        assign sel_vec[gi] = ready[gi] && !(|(col & ready));
    end

    // Priority encoders for issue and free slot, plus occupancy count.
    always_comb begin
        have_sel = 1'b0;
        sel_idx  = '0;
        free_idx = '0;
        count    = '0;
        for (int unsigned i = RS_SIZE; i > 0; i--) begin
            if (sel_vec[i-1]) begin
                have_sel = 1'b1;
                sel_idx  = RS_WIDTH'(i - 1);
            end
            if (!busy[i-1]) begin
                free_idx = RS_WIDTH'(i - 1);
            end
            count = count + CNT_W'(busy[i-1]);
        end
    end

    rs_alu u_alu (
        .op     (e_op[sel_idx]),
        .vj     (e_vj[sel_idx]),
        .vk     (e_vk[sel_idx]),
        .imm    (e_imm[sel_idx]),
        .pc     (e_pc[sel_idx]),
        .result (alu_res)
    );

    // Entry state, age matrix and the registered result slot.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy      <= '0;
            out_valid <= 1'b0;
            out_rob   <= '0;
            out_data  <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                e_op[i]  <= '0;
                e_vj[i]  <= '0;
                e_vk[i]  <= '0;
                e_imm[i] <= '0;
                e_pc[i]  <= '0;
                e_qj[i]  <= NON_DEP;
                e_qk[i]  <= NON_DEP;
                e_rob[i] <= '0;
                older[i] <= '0;
            end
        end else if (flush_in) begin
            busy      <= '0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                older[i] <= '0;
            end
        end else if (rdy_in) begin
            if (cdb_valid) begin
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && e_qj[i] == cdb_tag) begin
                        e_qj[i] <= NON_DEP;
                        e_vj[i] <= cdb_data;
                    end
                    if (busy[i] && e_qk[i] == cdb_tag) begin
                        e_qk[i] <= NON_DEP;
                        e_vk[i] <= cdb_data;
                    end
                end
            end

            if (do_issue) begin
                busy[sel_idx] <= 1'b0;
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    older[i][sel_idx] <= 1'b0;
                end
                out_valid <= 1'b1;
                out_rob   <= e_rob[sel_idx];
                out_data  <= alu_res;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // The allocated slot is never the issuing one (it was free), so
            // these writes only overlap the issue's column clear at zeros.
            if (do_alloc) begin
                busy[free_idx]  <= 1'b1;
                e_op[free_idx]  <= disp_op;
                e_imm[free_idx] <= disp_imm;
                e_pc[free_idx]  <= disp_pc;
                e_rob[free_idx] <= disp_rob;
                if (cdb_valid && disp_qj == cdb_tag) begin
                    e_qj[free_idx] <= NON_DEP;
                    e_vj[free_idx] <= cdb_data;
                end else begin
                    e_qj[free_idx] <= disp_qj;
                    e_vj[free_idx] <= disp_vj;
                end
                if (cdb_valid && disp_qk == cdb_tag) begin
                    e_qk[free_idx] <= NON_DEP;
                    e_vk[free_idx] <= cdb_data;
                end else begin
                    e_qk[free_idx] <= disp_qk;
                    e_vk[free_idx] <= disp_vk;
                end
                older[free_idx] <= '0;
                for (int unsigned i = 0; i < RS_SIZE; i++) begin
                    older[i][free_idx] <= busy[i] && !(do_issue && sel_idx == RS_WIDTH'(i));
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_aged.sv
// Randomized and directed bench for alu_rs_aged against an age-ordered queue model.
module tb_alu_rs_aged;

    localparam logic [3:0]  ND   = 4'd8;
    localparam logic [31:0] SIGN = 32'h8000_0000;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid, disp_ready;
    logic [6:0]  disp_op;
    logic [2:0]  disp_rob;
    logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
    logic [3:0]  disp_qj, disp_qk;
    logic        cdb_valid;
    logic [2:0]  cdb_rob;
    logic [31:0] cdb_data;
    logic        out_valid, out_ready;
    logic [2:0]  out_rob;
    logic [31:0] out_data;
    logic [3:0]  count;

    alu_rs_aged #(.RS_WIDTH(3), .ROB_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_rob(disp_rob), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
        .out_data(out_data), .count(count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: entries kept in allocation order, oldest at the front.
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  rob;
        logic [31:0] vj, vk, imm;
        logic [3:0]  qj, qk;
    } ment_t;

    ment_t       mq[$];
    logic        m_ov;
    logic [2:0]  m_rob;
    logic [31:0] m_data;

    function automatic logic [31:0] asr(input logic [31:0] x, input logic [4:0] sh);
        logic [31:0] r;
        r = x >> sh;
        if (x[31]) r = r | ~(32'hFFFF_FFFF >> sh);
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] imm);
        logic slt_ab, slt_ai;
        slt_ab = (a ^ SIGN) < (b ^ SIGN);
        slt_ai = (a ^ SIGN) < (imm ^ SIGN);
        case (op)
            7'd4:  return ((a + imm) >> 1) << 1;
            7'd5:  return 32'(a == b);
            7'd6:  return 32'(a != b);
            7'd7:  return 32'(slt_ab);
            7'd8:  return 32'(!slt_ab);
            7'd9:  return 32'(a < b);
            7'd10: return 32'(!(a < b));
            7'd19: return a + imm;
            7'd20: return 32'(slt_ai);
            7'd21: return 32'(a < imm);
            7'd22: return a ^ imm;
            7'd23: return a | imm;
            7'd24: return a & imm;
            7'd25: return a << (imm % 32);
            7'd26: return a >> (imm % 32);
            7'd27: return asr(a, imm[4:0]);
            7'd28: return a + b;
            7'd29: return a + (~b + 32'd1);
            7'd30: return a << (b % 32);
            7'd31: return 32'(slt_ab);
            7'd32: return 32'(a < b);
            7'd33: return a ^ b;
            7'd34: return a >> (b % 32);
            7'd35: return asr(a, b[4:0]);
            7'd36: return a | b;
            7'd37: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0;
        m_rob = '0;
        m_data = '0;
    endtask

    // One clock: advance the model with the held inputs, then compare.
    task automatic step();
        bit    accept;
        int    sel;
        ment_t e;
        @(posedge clk_in);
        if (flush_in) begin
            mq.delete();
            m_ov = 1'b0;
        end else if (rdy_in) begin
            accept = disp_valid && (mq.size() < 8);
            sel = -1;
            foreach (mq[i]) if (sel < 0 && mq[i].qj == ND && mq[i].qk == ND) sel = i;
            if (sel >= 0 && (!m_ov || out_ready)) begin
                m_ov   = 1'b1;
                m_rob  = mq[sel].rob;
                m_data = ref_alu(mq[sel].op, mq[sel].vj, mq[sel].vk, mq[sel].imm);
                mq.delete(sel);
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (cdb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].qj == {1'b0, cdb_rob}) begin mq[i].qj = ND; mq[i].vj = cdb_data; end
                    if (mq[i].qk == {1'b0, cdb_rob}) begin mq[i].qk = ND; mq[i].vk = cdb_data; end
                end
            end
            if (accept) begin
                e.op = disp_op; e.rob = disp_rob; e.imm = disp_imm;
                e.vj = disp_vj; e.qj = disp_qj;
                e.vk = disp_vk; e.qk = disp_qk;
                if (cdb_valid && disp_qj == {1'b0, cdb_rob}) begin e.qj = ND; e.vj = cdb_data; end
                if (cdb_valid && disp_qk == {1'b0, cdb_rob}) begin e.qk = ND; e.vk = cdb_data; end
                mq.push_back(e);
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_rob", 32'(out_rob), 32'(m_rob));
            check("out_data", out_data, m_data);
        end
        check("count", 32'(count), 32'(mq.size()));
        check("disp_ready", 32'(disp_ready), 32'(rdy_in && mq.size() < 8));
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] rob, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [31:0] imm,
                        input logic [3:0] qj, input logic [3:0] qk);
        disp_valid = 1'b1; disp_op = op; disp_rob = rob; disp_vj = vj; disp_vk = vk;
        disp_imm = imm; disp_pc = $urandom; disp_qj = qj; disp_qk = qk;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
    endtask

    task automatic cdb(input logic [2:0] rob, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_rob = rob; cdb_data = data;
    endtask

    function automatic logic [6:0] rand_op();
        int unsigned r;
        r = $urandom_range(0, 26);
        if (r == 0) return 7'd4;
        if (r <= 6) return 7'(4 + r);
        if (r <= 25) return 7'(12 + r);
        return 7'd50;
    endfunction

    logic [6:0]  c_op   [4] = '{7'd31, 7'd32, 7'd35, 7'd4};
    logic [31:0] c_vj   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_1001};
    logic [31:0] c_vk   [4] = '{32'd1, 32'd1, 32'd33, 32'd0};
    logic [31:0] c_exp  [4] = '{32'd1, 32'd0, 32'hC000_0000, 32'h0000_1000};

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
        disp_valid = 1'b0; disp_op = '0; disp_rob = '0; disp_vj = '0; disp_vk = '0;
        disp_imm = '0; disp_pc = '0; disp_qj = ND; disp_qk = ND;
        cdb_valid = 1'b0; cdb_rob = '0; cdb_data = '0;
        model_reset();
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_rob", 32'(out_rob), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_disp_ready_frozen", 32'(disp_ready), 32'd0);
        rst_in = 1'b0;
        rdy_in = 1'b1;
        #1;
        check("disp_ready_idle", 32'(disp_ready), 32'd1);

        // Oldest-first: younger ready B issues before older waiting A.
        disp(7'd28, 3'd5, 32'd0, 32'd1, 32'd0, 4'd2, ND); step();
        disp(7'd28, 3'd6, 32'd10, 32'd20, 32'd0, ND, ND); step();
        idle(); cdb(3'd2, 32'd100); step();
        check("order_b_rob", 32'(out_rob), 32'd6);
        check("order_b_data", out_data, 32'd30);
        idle(); step();
        check("order_a_rob", 32'(out_rob), 32'd5);
        check("order_a_data", out_data, 32'd101);
        idle(); step();

        // Tie: both wake on the same broadcast, older goes first.
        disp(7'd28, 3'd5, 32'd0, 32'd1, 32'd0, 4'd2, ND); step();
        disp(7'd28, 3'd6, 32'd0, 32'd2, 32'd0, 4'd2, ND); step();
        idle(); cdb(3'd2, 32'd40); step();
        idle(); step();
        check("tie_first_rob", 32'(out_rob), 32'd5);
        step();
        check("tie_second_rob", 32'(out_rob), 32'd6);
        check("tie_second_data", out_data, 32'd42);
        step();

        // Dispatch-time bypass, 2-edge latency.
        disp(7'd28, 3'd1, 32'd0, 32'd5, 32'd0, 4'd3, ND); cdb(3'd3, 32'd7); step();
        idle(); step();
        check("bypass_valid", 32'(out_valid), 32'd1);
        check("bypass_data", out_data, 32'd12);

        // ALU corner values.
        for (int i = 0; i < 4; i++) begin
            disp(c_op[i], 3'(i), c_vj[i], c_vk[i], 32'd0, ND, ND); step();
            idle(); step();
            check($sformatf("alu_corner%0d", i), out_data, c_exp[i]);
        end
        step();

        // Back-pressure: result held, three entries wait, then drain in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            disp(7'd28, 3'(i), 32'(i * 16), 32'd0, 32'd0, ND, ND); step();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_rob", 32'(out_rob), 32'd1);
            check("hold_data", out_data, 32'd16);
            check("hold_count", 32'(count), 32'd3);
        end
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            step();
            check("drain_rob", 32'(out_rob), 32'(i));
            check("drain_valid", 32'(out_valid), 32'd1);
        end
        step();
        check("drain_done", 32'(out_valid), 32'd0);

        // Full: eight unready entries, ninth dispatch dropped.
        for (int i = 0; i < 8; i++) begin
            disp(7'd28, 3'(i), 32'd0, 32'd0, 32'd0, 4'd1, ND); step();
        end
        check("full_disp_ready", 32'(disp_ready), 32'd0);
        check("full_count", 32'(count), 32'd8);
        disp(7'd28, 3'd7, 32'd0, 32'd0, 32'd0, ND, ND); step();
        check("full_dropped_count", 32'(count), 32'd8);
        idle(); flush_in = 1'b1; step(); flush_in = 1'b0;
        check("flush_full_count", 32'(count), 32'd0);

        // Flush with a held result and four busy entries.
        out_ready = 1'b0;
        disp(7'd19, 3'd2, 32'd3, 32'd0, 32'd4, ND, ND); step();
        for (int i = 0; i < 4; i++) begin
            disp(7'd28, 3'(i + 3), 32'd0, 32'd0, 32'd0, 4'd1, ND); step();
        end
        idle();
        check("pre_flush_valid", 32'(out_valid), 32'd1);
        check("pre_flush_count", 32'(count), 32'd4);
        flush_in = 1'b1; step(); flush_in = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_count", 32'(count), 32'd0);

        // Asynchronous reset while a result is held.
        disp(7'd28, 3'd4, 32'd9, 32'd9, 32'd0, ND, ND); step();
        disp(7'd28, 3'd5, 32'd9, 32'd9, 32'd0, ND, ND); step();
        idle();
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        model_reset();
        #2 rst_in = 1'b0;
        out_ready = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rdy_in    = ($urandom_range(0, 15) != 0);
            flush_in  = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            disp_valid = $urandom_range(0, 1);
            disp_op   = rand_op();
            disp_rob  = 3'($urandom);
            disp_vj   = $urandom;
            disp_vk   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            disp_imm  = $urandom;
            disp_pc   = $urandom;
            disp_qj   = ($urandom_range(0, 9) < 6) ? ND : 4'($urandom_range(0, 7));
            disp_qk   = ($urandom_range(0, 9) < 6) ? ND : 4'($urandom_range(0, 7));
            cdb_valid = $urandom_range(0, 1);
            cdb_rob   = 3'($urandom);
            cdb_data  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
